pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and fetch-address stage for the 8-bit MIPS core. It holds the PC, presents it to instruction memory as the fetch address, and computes the next PC. The next PC is one of: sequential increment, PC-relative branch, absolute jump, hold on stall, or freeze on halt. Both additions use ripple-carry adders built from the team's full-adder cell. The stage sits directly upstream of instruction memory and the IF/ID register.

## Interface
Parameters:
- `ADDR_W`, 8, PC/instruction-address width
- `RESET_ADDR`, 8'h00, PC value loaded on reset

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hold the PC this cycle (hazard unit)
- `halt`  in  1  enter the sticky HALT state
- `jump`  in  1  load `jump_target` into the PC
- `jump_target`  in  ADDR_W  absolute jump address
- `branch_taken`  in  1  load the PC-relative branch target
- `branch_offset`  in  ADDR_W  two's-complement offset, relative to PC+1
- `im_addr`  out  ADDR_W  current PC, driven to instruction memory
- `pc_plus1`  out  ADDR_W  PC+1, combinational from the PC (link value / IF/ID)
- `fetch_valid`  out  1  `im_addr` is a live fetch
- `stalled`  out  1  high while in the STALL state

## Operation
- **FSM states:** BOOT, RUN, STALL, HALT.
- **Moore outputs:**
  - `fetch_valid` = 1 in RUN and STALL; 0 in BOOT and HALT.
  - `stalled` = 1 only in STALL.
- **Reset** (`rst` sampled high, in any state): PC = `RESET_ADDR`, state = BOOT.
- **BOOT:** always goes to RUN on the next edge with the PC unchanged. `stall`, `halt`, `jump` and `branch_taken` are ignored.
- **RUN / STALL** next-state priority, highest first:
  - `halt` → HALT, PC held.
  - `jump` → RUN, PC = `jump_target`.
  - `branch_taken` → RUN, PC = `pc_plus1 + branch_offset`.
  - `stall` → STALL, PC held.
  - otherwise → RUN, PC = `pc_plus1`.
- **HALT:** PC frozen; every input except `rst` is ignored.
- **Redirect over stall:** a jump or branch asserted together with `stall` takes effect; the stall is dropped for that cycle.
- **Jump over branch:** `jump` and `branch_taken` both high → jump wins.
- **Arithmetic:**
  - All sums are modulo 2^ADDR_W; carry-out is discarded.
  - Wrap-around: 0xFF+1 = 0x00.
  - Branch: `pc_plus1 + branch_offset`, e.g. PC 0x02, offset 0xFC (−4) → 0xFF.
  - No overflow flag.

## Timing
- **Reset values:** `im_addr` = `RESET_ADDR`, `pc_plus1` = `RESET_ADDR`+1, `fetch_valid` = 0, `stalled` = 0.
- **First live fetch:** `fetch_valid` first rises one cycle after `rst` is released; `im_addr` = `RESET_ADDR` on that cycle.
- **Redirect latency:** 1 cycle. A redirect sampled at edge t gives `im_addr` = target after edge t.
- **Wrong-path flush:** the instruction fetched in the redirect cycle is wrong-path. The IF/ID register flushes it, driven by `jump | branch_taken`; this block inserts no bubble.
- **Stall:** `stall` held for N cycles gives N cycles with the PC unchanged and `stalled` = 1. The PC advances on the first edge where `stall` = 0.
- **Combinational paths:** `pc_plus1` and the branch target are functions of the PC and inputs only. No combinational input→`im_addr` path; `im_addr` is registered.
- **Reset priority:** reset mid-stall, mid-halt or during a redirect wins on that edge.

## Structure
- **Shared include `pc_defs.vh`:** state encodings (BOOT=2'd0, RUN=2'd1, STALL=2'd2, HALT=2'd3) and defaults for `ADDR_W` and `RESET_ADDR`.
- **Sub-module `pc_adder`:** ADDR_W-bit ripple-carry adder, generated from `full_adder` cells, with ports `a`, `b`, `cin`, `sum`. Two instances:
  - increment: `a` = PC, `b` = 0, `cin` = 1;
  - branch: `a` = `pc_plus1`, `b` = `branch_offset`, `cin` = 0.
- **Top level:** PC register, state register, next-state/next-PC mux.

## Test plan
- **Reset, then run 3 cycles:**
  - cycle 0 after release: `im_addr` = 0x00, `fetch_valid` = 0 (BOOT);
  - next 3 cycles: `fetch_valid` = 1, `im_addr` = 0x00, 0x01, 0x02.
- **Wrap:** free-running through 0xFE, 0xFF → next `im_addr` 0x00, `pc_plus1` = 0x01.
- **Branch and jump:**
  - At PC 0x10, `branch_taken` with offset 0x05 → next PC 0x16.
  - At PC 0x10, offset 0xF0 → 0x01.
  - `jump` and `branch_taken` together with `jump_target` 0x40 → 0x40.
- **Stall:**
  - `stall` for 3 cycles at PC 0x20 → `im_addr` stays 0x20, `stalled` = 1 for 3 cycles, then 0x21.
  - `stall` plus `jump` to 0x80 → 0x80, `stalled` = 0.
- **Halt:** `halt` at PC 0x33 → `fetch_valid` 0, PC stays 0x33 while `jump`/`branch_taken`/`stall` toggle; `rst` → PC 0x00, BOOT.
- **Reset mid-stall:** → `im_addr` = `RESET_ADDR`, `fetch_valid` = 0, `stalled` = 0 on the next cycle.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC / fetch-address stage: FSM state encodings
// and default parameter values.
package pc_fetch_pkg;

    localparam int unsigned PC_ADDR_W_DEFAULT = 8;
    localparam logic [7:0]  PC_RESET_DEFAULT  = 8'h00;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    // Moore decode of the fetch-valid output for a given state.
    function automatic logic state_fetch_valid(input pc_state_e s);
        return (s == ST_RUN) || (s == ST_STALL);
    endfunction

endpackage

// File: rtl/pc_adder.sv
// Full-adder cell and the ADDR_W-bit ripple-carry adder built from it.
// The final carry-out is dropped, so every sum wraps modulo 2^W.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // One-bit sum and carry.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

module pc_adder #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    logic [W:0] carry;
    logic       unused_carry_out;

    assign carry[0]         = cin;
    // Carry out of the top bit has no consumer: sums wrap, no overflow flag.
    assign unused_carry_out = carry[W];

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch-address stage of the 8-bit MIPS core.
// Holds the PC, drives it to instruction memory and selects the next PC
// among increment, PC-relative branch, absolute jump, stall hold and halt.
//
// Output semantics: im_addr is a live fetch exactly when fetch_valid is high.
// There is no back-pressure from instruction memory; the only hold
// mechanism is the stall input, which keeps im_addr stable (fetch_valid stays
// high) for as many cycles as stall is held. Redirects (jump/branch_taken)
// take effect on the edge they are sampled; the instruction fetched in that
// cycle is wrong-path and is flushed downstream by IF/ID, not here.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = PC_ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_ADDR = PC_RESET_DEFAULT[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              fetch_valid,
    output logic              stalled,
    output pc_state_e         fsm_state
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] branch_target;
    pc_state_e         state_q;

    // PC + 1 through the increment adder.
    pc_adder #(.W(ADDR_W)) u_inc (
        .a   (pc_q),
        .b   ('0),
        .cin (1'b1),
        .sum (pc_plus1)
    );

    // Branch target is relative to the sequential successor, not the PC.
    pc_adder #(.W(ADDR_W)) u_branch (
        .a   (pc_plus1),
        .b   (branch_offset),
        .cin (1'b0),
        .sum (branch_target)
    );

    assign im_addr   = pc_q;
    assign fsm_state = state_q;

    // State, PC and registered Moore outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_ADDR;
            fetch_valid <= 1'b0;
            stalled     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_q     <= ST_RUN;
                    fetch_valid <= state_fetch_valid(ST_RUN);
                    stalled     <= 1'b0;
                end
                ST_RUN, ST_STALL: begin
                    // Halt beats redirects; redirects beat stall; jump beats branch.
                    if (halt) begin
                        state_q     <= ST_HALT;
                        fetch_valid <= state_fetch_valid(ST_HALT);
                        stalled     <= 1'b0;
                    end else if (jump) begin
                        state_q     <= ST_RUN;
                        pc_q        <= jump_target;
                        fetch_valid <= state_fetch_valid(ST_RUN);
                        stalled     <= 1'b0;
                    end else if (branch_taken) begin
                        state_q     <= ST_RUN;
                        pc_q        <= branch_target;
                        fetch_valid <= state_fetch_valid(ST_RUN);
                        stalled     <= 1'b0;
                    end else if (stall) begin
                        state_q     <= ST_STALL;
                        fetch_valid <= state_fetch_valid(ST_STALL);
                        stalled     <= 1'b1;
                    end else begin
                        state_q     <= ST_RUN;
                        pc_q        <= pc_plus1;
                        fetch_valid <= state_fetch_valid(ST_RUN);
                        stalled     <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state_q     <= ST_HALT;
                    fetch_valid <= 1'b0;
                    stalled     <= 1'b0;
                end
                default: begin
                    state_q     <= ST_BOOT;
                    fetch_valid <= 1'b0;
                    stalled     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, sequencing, wrap, branch/jump,
// stall, halt and reset-priority cases with hand-computed expectations.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       halt;
    logic       jump;
    logic [7:0] jump_target;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic [7:0] im_addr;
    logic [7:0] pc_plus1;
    logic       fetch_valid;
    logic       stalled;
    pc_state_e  fsm_state;

    int total;
    int bad;

    pc_fetch #(.ADDR_W(8), .RESET_ADDR(8'h00)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .halt          (halt),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .im_addr       (im_addr),
        .pc_plus1      (pc_plus1),
        .fetch_valid   (fetch_valid),
        .stalled       (stalled),
        .fsm_state     (fsm_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; jump = 0; branch_taken = 0;
        jump_target = 8'h00; branch_offset = 8'h00;
    endtask

    task automatic do_jump(input logic [7:0] t);
        jump = 1; jump_target = t;
        step();
        jump = 0;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] a, input logic fv, input logic st);
        chk({tag, ".im_addr"}, 32'(im_addr), 32'(a));
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
        chk({tag, ".stalled"}, 32'(stalled), 32'(st));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst = 1;

        // Reset state (still in BOOT after the reset edge).
        step();
        chk_out("reset", 8'h00, 0, 0);
        chk("reset.pc_plus1", 32'(pc_plus1), 32'h01);
        chk("reset.state", 32'(fsm_state), 32'(ST_BOOT));

        // First live fetch, then sequential run.
        rst = 0;
        step();
        chk_out("run0", 8'h00, 1, 0);
        chk("run0.state", 32'(fsm_state), 32'(ST_RUN));
        step();
        chk_out("run1", 8'h01, 1, 0);
        step();
        chk_out("run2", 8'h02, 1, 0);

        // Wrap-around.
        do_jump(8'hFE);
        chk_out("wrap_fe", 8'hFE, 1, 0);
        step();
        chk_out("wrap_ff", 8'hFF, 1, 0);
        chk("wrap_ff.pc_plus1", 32'(pc_plus1), 32'h00);
        step();
        chk_out("wrap_00", 8'h00, 1, 0);
        chk("wrap_00.pc_plus1", 32'(pc_plus1), 32'h01);

        // Branch forward: 0x10 + 1 + 0x05 = 0x16.
        do_jump(8'h10);
        branch_taken = 1; branch_offset = 8'h05;
        step();
        branch_taken = 0;
        chk_out("br_fwd", 8'h16, 1, 0);

        // Branch backward: 0x10 + 1 + 0xF0 = 0x01 (mod 256).
        do_jump(8'h10);
        branch_taken = 1; branch_offset = 8'hF0;
        step();
        branch_taken = 0;
        chk_out("br_back", 8'h01, 1, 0);

        // Branch wrapping below zero: 0x02 + 1 + 0xFC = 0xFF.
        do_jump(8'h02);
        branch_taken = 1; branch_offset = 8'hFC;
        step();
        branch_taken = 0;
        chk_out("br_neg4", 8'hFF, 1, 0);

        // Jump beats branch.
        jump = 1; jump_target = 8'h40; branch_taken = 1; branch_offset = 8'h05;
        step();
        jump = 0; branch_taken = 0;
        chk_out("jmp_over_br", 8'h40, 1, 0);

        // Stall three cycles at 0x20, then advance.
        do_jump(8'h20);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall%0d", i), 8'h20, 1, 1);
        end
        chk("stall.state", 32'(fsm_state), 32'(ST_STALL));
        stall = 0;
        step();
        chk_out("stall_rel", 8'h21, 1, 0);

        // Redirect over stall.
        stall = 1; jump = 1; jump_target = 8'h80;
        step();
        stall = 0; jump = 0;
        chk_out("jmp_over_stall", 8'h80, 1, 0);

        // Halt freezes PC; other inputs ignored.
        do_jump(8'h33);
        halt = 1;
        step();
        halt = 0;
        chk_out("halt", 8'h33, 0, 0);
        chk("halt.state", 32'(fsm_state), 32'(ST_HALT));
        for (int i = 0; i < 4; i++) begin
            jump = i[0]; jump_target = 8'h77;
            branch_taken = i[1]; branch_offset = 8'h10;
            stall = ~i[0];
            step();
            chk_out($sformatf("halt_hold%0d", i), 8'h33, 0, 0);
        end
        idle_inputs();

        // Reset out of halt.
        rst = 1;
        step();
        rst = 0;
        chk_out("halt_rst", 8'h00, 0, 0);
        chk("halt_rst.state", 32'(fsm_state), 32'(ST_BOOT));
        step();
        chk_out("halt_rst_run", 8'h00, 1, 0);

        // Reset mid-stall.
        step();
        chk_out("pre_stall", 8'h01, 1, 0);
        stall = 1;
        step();
        chk_out("mid_stall", 8'h01, 1, 1);
        rst = 1;
        step();
        rst = 0; stall = 0;
        chk_out("stall_rst", 8'h00, 0, 0);
        step();
        chk_out("stall_rst_run", 8'h00, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
